esn_sequencer: RTL and testbench
================================

// Module: esn_sequencer
// PURPOSE
//   Parametrised step sequencer for the integer echo state network; successor to the
//   two-phase reservoir/interpreter handler. Runs a programmable number of time steps,
//   each a reservoir update followed by an interpreter (readout) pass. Adds ready
//   handshakes on both phases, washout steps, a per-phase watchdog, abort and done/error
//   reporting. Sits between the top-level controller and the reservoir/interpreter datapaths.
// PARAMETERS
//   STEP_W   16    width of step count / step index
//   WASHOUT  4     leading steps that run the reservoir only (interpreter skipped)
//   TO_W     12    width of watchdog counter
//   TIMEOUT  4000  max cycles in one phase before error (must fit TO_W bits, >0)
// PORTS
//   iClk          in   1       clock, all logic on rising edge
//   iRst          in   1       synchronous reset, active-high
//   iStart        in   1       start request, sampled only in IDLE
//   iAbort        in   1       abort run, highest priority after reset
//   iNumSteps     in   STEP_W  total steps for the run, latched on accepted start
//   iResRdy       in   1       reservoir finished current update
//   iIntRdy       in   1       interpreter finished current readout
//   oEnReserv     out  1       reservoir enable, high for the whole RES phase
//   oEnInterp     out  1       interpreter enable, high for the whole INT phase
//   oStep         out  STEP_W  index of current step (0-based)
//   oBusy         out  1       high in RES or INT
//   oDone         out  1       one-cycle pulse on successful completion
//   oErr          out  1       sticky watchdog error flag
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, all outputs 0, counters 0.
//   - States: IDLE, RES, INT, DONE, ERR (one-hot encoding).
//   - IDLE: iStart=1 -> latch N=iNumSteps, oStep<=0. N==0 -> DONE; else -> RES,
//     oEnReserv<=1 (visible the cycle after the start edge). iStart ignored elsewhere.
//   - RES: hold oEnReserv=1 until iResRdy=1. At that edge oEnReserv<=0 and:
//       oStep<WASHOUT -> end-of-step (interpreter skipped);
//       else -> INT, oEnInterp<=1.
//   - INT: hold oEnInterp=1 until iIntRdy=1; at that edge oEnInterp<=0 -> end-of-step.
//   - End-of-step: oStep==N-1 -> DONE; else oStep<=oStep+1, -> RES, oEnReserv<=1.
//     No idle cycle between consecutive steps. If WASHOUT>=N no INT phase ever occurs.
//   - DONE: oDone=1 for exactly one cycle, then IDLE; oStep keeps last index.
//   - Ready inputs are ignored outside their own phase (iIntRdy in RES has no effect).
//   - Minimum step time: 1 cycle per phase (ready already high on phase entry).
//   - Watchdog: counter cleared on every phase entry, increments each cycle in RES/INT.
//     Ready on the same edge the count reaches TIMEOUT-1 wins. Count reaching
//     TIMEOUT-1 without ready -> ERR: enables<=0, oErr<=1.
//   - ERR: oErr held, oBusy=0; only iAbort or iRst leaves (-> IDLE, oErr<=0).
//   - iAbort=1 in any state: next state IDLE, oEnReserv/oEnInterp/oBusy/oErr <=0,
//     no oDone pulse, oStep<=0. iAbort and iStart together in IDLE: abort wins.
//   - iRst takes precedence over every input; reset mid-run behaves as abort.
//   - oBusy = registered (next state is RES or INT).
// TESTING
//   1. iNumSteps=6, WASHOUT=4, ready 3 cycles after enable -> 6 oEnReserv pulses, 2
//      oEnInterp pulses (oStep 4,5), oStep 0..5, single oDone after last iIntRdy.
//   2. iNumSteps=0 with iStart -> oDone next cycle, no enables, oBusy stays 0.
//   3. iResRdy/iIntRdy tied high, N=8, WASHOUT=0 -> one cycle per phase, 16 cycles
//      busy, oEnReserv/oEnInterp alternate with no gaps.
//   4. iIntRdy never asserted, TIMEOUT=16 -> oErr=1 16 cycles after INT entry,
//      enables 0; iStart ignored; iAbort -> oErr=0, state IDLE.
//   5. iAbort at step 3 mid-RES -> enables 0 next cycle, oStep=0, no oDone; new
//      iStart then runs a full clean sequence.
//   6. iRst asserted mid-INT and iStart+iAbort same cycle in IDLE -> all outputs 0,
//      no run started.

Source files
------------

// File: rtl/esn_sequencer.sv
// rtl/esn_sequencer.sv - step sequencer for the integer echo state network
//
// Runs iNumSteps time steps. Each step is a reservoir update (RES phase) and,
// once the first WASHOUT steps are over, an interpreter readout (INT phase).
// Both phases finish on a ready handshake and are guarded by a watchdog.
//
// Ports:
//   iClk, iRst       clock and synchronous active-high reset
//   iStart           start request, only honoured in IDLE
//   iAbort           abort the run from any state
//   iNumSteps        step count, latched when a start is accepted
//   iResRdy/iIntRdy  phase-complete handshakes from the datapaths
//   oEnReserv        reservoir enable, high for the whole RES phase
//   oEnInterp        interpreter enable, high for the whole INT phase
//   oStep            0-based index of the current step
//   oBusy            high while in RES or INT
//   oDone            one-cycle pulse when a run completes
//   oErr             sticky watchdog error, cleared by abort or reset
module esn_sequencer #(
    parameter int STEP_W  = 16,
    parameter int WASHOUT = 4,
    parameter int TO_W    = 12,
    parameter int TIMEOUT = 4000
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [STEP_W-1:0] iNumSteps,
    input  logic              iResRdy,
    input  logic              iIntRdy,
    output logic              oEnReserv,
    output logic              oEnInterp,
    output logic [STEP_W-1:0] oStep,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_RES  = 5'b00010,
        S_INT  = 5'b00100,
        S_DONE = 5'b01000,
        S_ERR  = 5'b10000
    } state_t;

    // One bit wider than the step index so any WASHOUT up to 2^STEP_W compares cleanly.
    localparam logic [STEP_W:0] WASH_EXT = (STEP_W+1)'(WASHOUT);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] n_q, n_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              en_res_q, en_res_d;
    logic              en_int_q, en_int_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              step_end;
    logic              last_step;
    logic              in_washout;

    assign last_step  = (step_q == n_q - STEP_W'(1));
    assign in_washout = ({1'b0, step_q} < WASH_EXT);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        step_d   = step_q;
        wd_d     = wd_q;
        en_res_d = 1'b0;
        en_int_d = 1'b0;
        err_d    = err_q;
        step_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    n_d    = iNumSteps;
                    step_d = '0;
                    wd_d   = '0;
                    if (iNumSteps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_RES;
                        en_res_d = 1'b1;
                    end
                end
            end
            S_RES: begin
                // Ready is checked before the watchdog so a late ready still wins.
                if (iResRdy) begin
                    wd_d = '0;
                    if (in_washout) begin
                        step_end = 1'b1;
                    end else begin
                        state_d  = S_INT;
                        en_int_d = 1'b1;
                    end
                end else if (wd_q == TO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    en_res_d = 1'b1;
                    wd_d     = wd_q + TO_W'(1);
                end
            end
            S_INT: begin
                if (iIntRdy) begin
                    wd_d     = '0;
                    step_end = 1'b1;
                end else if (wd_q == TO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    en_int_d = 1'b1;
                    wd_d     = wd_q + TO_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Next step starts straight away in RES, no idle cycle in between.
        if (step_end) begin
            if (last_step) begin
                state_d = S_DONE;
            end else begin
                step_d   = step_q + STEP_W'(1);
                state_d  = S_RES;
                en_res_d = 1'b1;
            end
        end

        if (iAbort) begin
            state_d  = S_IDLE;
            step_d   = '0;
            wd_d     = '0;
            en_res_d = 1'b0;
            en_int_d = 1'b0;
            err_d    = 1'b0;
        end

        // Pulse and busy are derived from the final next state so abort suppresses both.
        done_d = (state_d == S_DONE);
        busy_d = (state_d == S_RES) || (state_d == S_INT);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            step_q   <= '0;
            wd_q     <= '0;
            en_res_q <= 1'b0;
            en_int_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            step_q   <= step_d;
            wd_q     <= wd_d;
            en_res_q <= en_res_d;
            en_int_q <= en_int_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign oEnReserv = en_res_q;
    assign oEnInterp = en_int_q;
    assign oStep     = step_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oErr      = err_q;

endmodule

// File: tb/tb_esn_sequencer.sv
// tb/tb_esn_sequencer.sv - self-checking bench for esn_sequencer
module tb_esn_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, res_rdy, int_rdy;
    logic [15:0] num;

    logic        a_en_res, a_en_int, a_busy, a_done, a_err;
    logic [15:0] a_step;
    logic        b_en_res, b_en_int, b_busy, b_done, b_err;
    logic [15:0] b_step;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    esn_sequencer #(.STEP_W(16), .WASHOUT(4), .TO_W(12), .TIMEOUT(16)) dut_a (
        .iClk(clk), .iRst(rst), .iStart(start), .iAbort(abort), .iNumSteps(num),
        .iResRdy(res_rdy), .iIntRdy(int_rdy),
        .oEnReserv(a_en_res), .oEnInterp(a_en_int), .oStep(a_step),
        .oBusy(a_busy), .oDone(a_done), .oErr(a_err)
    );

    esn_sequencer #(.STEP_W(16), .WASHOUT(0), .TO_W(12), .TIMEOUT(16)) dut_b (
        .iClk(clk), .iRst(rst), .iStart(start), .iAbort(abort), .iNumSteps(num),
        .iResRdy(res_rdy), .iIntRdy(int_rdy),
        .oEnReserv(b_en_res), .oEnInterp(b_en_int), .oStep(b_step),
        .oBusy(b_busy), .oDone(b_done), .oErr(b_err)
    );

    typedef struct {
        logic        rst, start, abort;
        logic [15:0] num;
        logic        res_rdy, int_rdy;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Expected status word: {en_res, en_int, busy, done, err, step}
    function automatic logic [20:0] st(input logic er, input logic ei, input logic bz,
                                       input logic dn, input logic e, input logic [15:0] s);
        return {er, ei, bz, dn, e, s};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic a, input logic [15:0] n,
                                input logic rr, input logic ir, input logic [20:0] x);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.num = n;
        v.res_rdy = rr; v.int_rdy = ir; v.exp = x;
        return v;
    endfunction

    function automatic logic [20:0] a_stat();
        return {a_en_res, a_en_int, a_busy, a_done, a_err, a_step};
    endfunction

    function automatic logic [20:0] b_stat();
        return {b_en_res, b_en_int, b_busy, b_done, b_err, b_step};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; abort = 0; res_rdy = 0; int_rdy = 0; num = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Ready answers on the third cycle of each phase; WASHOUT of dut_a is 4.
    task automatic run_full(input logic [15:0] n, input string tag);
        int rc, ic, busy_cyc, overlap, done_cyc, last_int_cyc, exp_busy;
        logic seen_done;
        int res_steps[$];
        int int_steps[$];
        rc = 0; ic = 0; busy_cyc = 0; overlap = 0; done_cyc = -1; last_int_cyc = -1;
        seen_done = 0;
        exp_busy = 3 * (int'(n) + ((n > 4) ? int'(n) - 4 : 0));
        idle_inputs();
        num = n; start = 1;
        tick();
        start = 0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (a_busy) busy_cyc++;
            if (a_en_res && a_en_int) overlap++;
            res_rdy = 0;
            int_rdy = 0;
            if (a_done) begin
                seen_done = 1;
                done_cyc = cyc;
            end else begin
                if (a_en_res) begin
                    rc++;
                    if (rc == 3) begin
                        res_rdy = 1;
                        res_steps.push_back(int'(a_step));
                        rc = 0;
                    end
                end else rc = 0;
                if (a_en_int) begin
                    ic++;
                    if (ic == 3) begin
                        int_rdy = 1;
                        int_steps.push_back(int'(a_step));
                        last_int_cyc = cyc;
                        ic = 0;
                    end
                end else ic = 0;
                tick();
            end
        end
        chk({tag, " done seen"}, 32'(seen_done), 32'd1);
        chk({tag, " busy cycles"}, 32'(busy_cyc), 32'(exp_busy));
        chk({tag, " enable overlap"}, 32'(overlap), 32'd0);
        chk({tag, " res phases"}, 32'(res_steps.size()), 32'(n));
        for (int i = 0; i < res_steps.size(); i++)
            chk($sformatf("%s res step %0d", tag, i), 32'(res_steps[i]), 32'(i));
        chk({tag, " int phases"}, 32'(int_steps.size()), (n > 4) ? 32'(n - 4) : 32'd0);
        for (int i = 0; i < int_steps.size(); i++)
            chk($sformatf("%s int step %0d", tag, i), 32'(int_steps[i]), 32'(i + 4));
        chk({tag, " done after last int"}, 32'(done_cyc), 32'(last_int_cyc + 1));
        idle_inputs();
        tick();
        chk({tag, " post done"}, 32'(a_stat()), 32'(st(0, 0, 0, 0, 0, n - 16'd1)));
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();

        // Table: dut_a single-cycle behaviour.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, st(0, 0, 0, 1, 0, 0)));   // N=0 -> immediate done
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 0, 2, 0, 0, st(1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, st(1, 0, 1, 0, 0, 1)));   // washout: no INT
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, st(0, 0, 0, 1, 0, 1)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 1)));   // step held after done
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, st(1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, st(1, 0, 1, 0, 0, 0)));   // iIntRdy ignored in RES
        vecs.push_back(mk(0, 1, 0, 5, 0, 0, st(1, 0, 1, 0, 0, 0)));   // iStart ignored in RES
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, st(0, 0, 0, 0, 0, 0)));   // abort beats ready
        vecs.push_back(mk(0, 1, 1, 3, 0, 0, st(0, 0, 0, 0, 0, 0)));   // abort beats start
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 0, 3, 0, 0, st(0, 0, 0, 0, 0, 0)));   // reset beats start
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, st(1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, st(0, 0, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, st(0, 0, 0, 0, 0, 0)));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
            num = vecs[i].num; res_rdy = vecs[i].res_rdy; int_rdy = vecs[i].int_rdy;
            tick();
            chk($sformatf("vec[%0d]", i), 32'(a_stat()), 32'(vecs[i].exp));
        end

        // Six steps, washout 4, ready on the third cycle of each phase.
        do_reset();
        run_full(16'd6, "run6");

        // WASHOUT=0, readies tied high: alternating one-cycle phases.
        do_reset();
        res_rdy = 1; int_rdy = 1; num = 8; start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("alt cycle %0d", k), 32'(b_stat()),
                32'(st(k % 2 == 0, k % 2 == 1, 1, 0, 0, 16'(k / 2))));
            tick();
        end
        chk("alt done", 32'(b_stat()), 32'(st(0, 0, 0, 1, 0, 7)));
        idle_inputs();

        // Watchdog: interpreter never answers.
        do_reset();
        begin
            bit found;
            found = 0;
            num = 6; start = 1; res_rdy = 1;
            tick();
            start = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (a_en_int) found = 1;
                else tick();
            end
            chk("wd reach int", 32'(found), 32'd1);
            for (int i = 0; i < 15; i++) tick();
            chk("wd before timeout", 32'(a_stat()), 32'(st(0, 1, 1, 0, 0, 4)));
            tick();
            chk("wd error", 32'(a_stat()), 32'(st(0, 0, 0, 0, 1, 4)));
            res_rdy = 0; start = 1; num = 3;
            tick();
            start = 0;
            chk("err ignores start", 32'(a_stat()), 32'(st(0, 0, 0, 0, 1, 4)));
            abort = 1;
            tick();
            abort = 0;
            chk("err abort", 32'(a_stat()), 32'(st(0, 0, 0, 0, 0, 0)));
        end

        // Abort at step 3 mid-RES, then a clean run.
        do_reset();
        begin
            bit found;
            found = 0;
            num = 6; start = 1; res_rdy = 1;
            tick();
            start = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (a_step == 16'd3) found = 1;
                else tick();
            end
            chk("abort reach step3", 32'(found), 32'd1);
            res_rdy = 0;
            tick();
            chk("mid res step3", 32'(a_stat()), 32'(st(1, 0, 1, 0, 0, 3)));
            abort = 1;
            tick();
            abort = 0;
            chk("abort mid res", 32'(a_stat()), 32'(st(0, 0, 0, 0, 0, 0)));
            tick();
            chk("abort no done", 32'(a_stat()), 32'(st(0, 0, 0, 0, 0, 0)));
            run_full(16'd6, "rerun6");
        end

        // Reset mid-INT, then start+abort together.
        do_reset();
        begin
            bit found;
            found = 0;
            num = 6; start = 1; res_rdy = 1;
            tick();
            start = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (a_en_int) found = 1;
                else tick();
            end
            chk("rst reach int", 32'(found), 32'd1);
            rst = 1;
            tick();
            rst = 0; res_rdy = 0;
            chk("rst mid int", 32'(a_stat()), 32'(st(0, 0, 0, 0, 0, 0)));
            start = 1; abort = 1; num = 6;
            tick();
            start = 0; abort = 0;
            chk("start+abort", 32'(a_stat()), 32'(st(0, 0, 0, 0, 0, 0)));
            tick();
            chk("no run started", 32'(a_stat()), 32'(st(0, 0, 0, 0, 0, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
